// File: rtl/strobe_scheduler_if.sv
// Request channel of the strobe scheduler.
// Master issues delayed writes; slave holds them until due.
interface strobe_scheduler_if #(
  parameter int DELAY_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic               req_value;
  logic [DELAY_W-1:0] req_delay;

  modport master (
    output req_valid,
    output req_value,
    output req_delay,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_value,
    input  req_delay,
    output req_ready
  );
endinterface

// File: rtl/strobe_scheduler.sv
// Delayed-assignment scheduler driving strobe; latest accept wins.
// Optional STROBE_SCHED_SQUASH_EN merges requests sharing a due cycle.
module strobe_scheduler #(
  parameter int   DEPTH       = 4,
  parameter int   DELAY_W     = 8,
  parameter logic INIT_STROBE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  strobe_scheduler_if.slave          req,
  output logic                       strobe,
  output logic                       strobe_chg,
  output logic                       fire,
  output logic [$clog2(DEPTH+1)-1:0] fire_n,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  // Two slots due together were accepted less than
  // 2^DELAY_W accepts apart, so this width orders them.
  localparam int SW = DELAY_W + 1;

  typedef logic [DELAY_W-1:0] cnt_t;
  typedef logic [SW-1:0]      stamp_t;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] val_q, val_d;
  cnt_t             cnt_q [DEPTH];
  cnt_t             cnt_d [DEPTH];
  stamp_t           stp_q [DEPTH];
  stamp_t           stp_d [DEPTH];
  stamp_t           seq_q, seq_d;

  logic [DEPTH-1:0] due, hit;
  logic [IW-1:0]    alloc;
  logic             acc, zero, now;
  logic             found, yval;
  stamp_t           ystp;
  logic [CW-1:0]    ndue, nfire, pend_d;
  logic             retire, new_strobe, chg_d;

  function automatic logic younger(
    input stamp_t a,
    input stamp_t b
  );
    stamp_t d;
    d = a - b;
    return (d != '0) && !d[SW-1];
  endfunction

  assign req.req_ready = ~&vld_q;

  // Decode due slots, the free slot to fill and squash matches.
  always_comb begin
    acc   = req.req_valid && req.req_ready;
    zero  = (req.req_delay == '0);
    now   = acc && zero;
    due   = '0;
    hit   = '0;
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      due[i] = vld_q[i] && (cnt_q[i] == '0);
      if (!vld_q[i]) alloc = IW'(i);
`ifdef STROBE_SCHED_SQUASH_EN
      hit[i] = vld_q[i] && !zero &&
               (cnt_q[i] == req.req_delay);
`else
      hit[i] = 1'b0;
`endif
    end
  end

  // Retire, count down, accept, and pick the winning value.
  always_comb begin
    vld_d = vld_q;
    val_d = val_q;
    cnt_d = cnt_q;
    stp_d = stp_q;
    seq_d = seq_q;
    found = 1'b0;
    yval  = 1'b0;
    ystp  = '0;
    ndue  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (due[i]) begin
        vld_d[i] = 1'b0;
        ndue     = ndue + CW'(1);
        if (!found || younger(stp_q[i], ystp)) begin
          found = 1'b1;
          ystp  = stp_q[i];
          yval  = val_q[i];
        end
      end else if (vld_q[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
    if (acc) begin
      seq_d = seq_q + stamp_t'(1);
      if (!zero && (hit != '0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (hit[i]) begin
            val_d[i] = req.req_value;
            stp_d[i] = seq_q;
          end
        end
      end else if (!zero) begin
        vld_d[alloc] = 1'b1;
        val_d[alloc] = req.req_value;
        cnt_d[alloc] = req.req_delay - cnt_t'(1);
        stp_d[alloc] = seq_q;
      end
    end
    retire     = found || now;
    new_strobe = now ? req.req_value :
                 (found ? yval : strobe);
    chg_d      = retire && (new_strobe != strobe);
`ifdef STROBE_SCHED_SQUASH_EN
    nfire = retire ? CW'(1) : '0;
`else
    nfire = ndue + {{(CW-1){1'b0}}, now};
`endif
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i]) pend_d = pend_d + CW'(1);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      seq_q      <= '0;
      strobe     <= INIT_STROBE;
      strobe_chg <= 1'b0;
      fire       <= 1'b0;
      fire_n     <= '0;
      pending    <= '0;
    end else begin
      vld_q      <= vld_d;
      seq_q      <= seq_d;
      strobe     <= new_strobe;
      strobe_chg <= chg_d;
      fire       <= retire;
      fire_n     <= nfire;
      pending    <= pend_d;
    end
  end

  // Slot payload; only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    cnt_q <= cnt_d;
    stp_q <= stp_d;
  end
endmodule
